// File: rtl/mux_grant_arbiter.sv
// ============================================================================
// mux_grant_arbiter : N-way fixed/round-robin arbiter steering a shared data mux
// Revision 1.0
// ============================================================================
`default_nettype none

module mux_grant_arbiter #(
   parameter int N_REQ    = 4,
   parameter int SEL_W    = 2,
   parameter int DW       = 8,
   parameter int MAX_HOLD = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mode,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ*DW-1:0]   din,
   output logic [N_REQ-1:0]      gnt,
   output logic [SEL_W-1:0]      sel,
   output logic                  gnt_valid,
   output logic [DW-1:0]         dout
);

   localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(MAX_HOLD - 1);
   localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_HANDOFF = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [HC_W-1:0]   hold_q, hold_d;
   logic              preempt_q, preempt_d;

   logic [N_REQ-1:0]  req_m;
   logic [SEL_W-1:0]  base;
   logic [SEL_W-1:0]  win;
   logic [N_REQ-1:0]  win_onehot;
   logic              found;
   logic              others_wait;
   int                idx;

   // A preempted owner sits out the handoff arbitration; a voluntary release does not.
   always_comb begin
      req_m      = req;
      base       = '0;
      win        = '0;
      found      = 1'b0;
      idx        = 0;
      win_onehot = '0;
      if (state_q == S_HANDOFF && preempt_q) begin
         req_m[sel_q] = 1'b0;
      end
      if (mode) begin
         base = rr_ptr_q;
      end
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(base) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!found && req_m[idx]) begin
            found = 1'b1;
            win   = SEL_W'(idx);
         end
      end
      win_onehot[win] = found;
   end

   assign others_wait = |(req & ~gnt_q);

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      rr_ptr_d  = rr_ptr_q;
      hold_d    = hold_q;
      preempt_d = preempt_q;
      case (state_q)
         S_IDLE, S_HANDOFF: begin
            preempt_d = 1'b0;
            if (found) begin
               state_d = S_GRANT;
               gnt_d   = win_onehot;
               sel_d   = win;
               hold_d  = '0;
               if (mode) begin
                  rr_ptr_d = (win == SEL_LAST) ? '0 : win + 1'b1;
               end
            end else begin
               state_d = S_IDLE;
               gnt_d   = '0;
            end
         end
         S_GRANT: begin
            if (hold_q != HOLD_LAST) begin
               hold_d = hold_q + 1'b1;
            end
            if (!req[sel_q]) begin
               state_d   = S_HANDOFF;
               gnt_d     = '0;
               preempt_d = 1'b0;
            end else if (hold_q == HOLD_LAST && others_wait) begin
               state_d   = S_HANDOFF;
               gnt_d     = '0;
               preempt_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         sel_q     <= '0;
         rr_ptr_q  <= '0;
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         rr_ptr_q  <= rr_ptr_d;
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end

   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign gnt_valid = (state_q == S_GRANT);
   assign dout      = gnt_valid ? din[sel_q*DW +: DW] : '0;

endmodule

`default_nettype wire

// File: tb/tb_mux_grant_arbiter.sv
// ============================================================================
// tb_mux_grant_arbiter : directed stimulus with a queued-expectation scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mux_grant_arbiter;

   logic        clk;
   logic        rst_n;
   logic        mode;
   logic [3:0]  req;
   logic [31:0] din;
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic        gnt_valid;
   logic [7:0]  dout;

   typedef struct {
      bit         chk;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       gv;
      logic [7:0] dout;
      int         tag;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   passed;
   bit   stim_done;

   mux_grant_arbiter #(
      .N_REQ    (4),
      .SEL_W    (2),
      .DW       (8),
      .MAX_HOLD (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .req       (req),
      .din       (din),
      .gnt       (gnt),
      .sel       (sel),
      .gnt_valid (gnt_valid),
      .dout      (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; the expectation pushed alongside them
   // describes the outputs after the following rising edge.
   task automatic cyc(input logic rn, input logic md, input logic [3:0] rq,
                      input logic [3:0] eg, input logic [1:0] es, input logic egv,
                      input logic [7:0] ed, input int tag);
      exp_t e;
      @(negedge clk);
      rst_n = rn;
      mode  = md;
      req   = rq;
      e.chk  = 1'b1;
      e.gnt  = eg;
      e.sel  = es;
      e.gv   = egv;
      e.dout = ed;
      e.tag  = tag;
      q.push_back(e);
   endtask

   task automatic own(input logic md, input logic [3:0] rq, input int o, input int tag);
      cyc(1'b1, md, rq, 4'(1 << o), 2'(o), 1'b1, 8'(8'hA0 + 8'h11 * o), tag);
   endtask

   task automatic gap(input logic md, input logic [3:0] rq, input int s, input int tag);
      cyc(1'b1, md, rq, 4'b0000, 2'(s), 1'b0, 8'h00, tag);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
               checks++;
               if (gnt !== e.gnt || sel !== e.sel || gnt_valid !== e.gv || dout !== e.dout) begin
                  $display("FAIL test%0d @%0t: got gnt=%b sel=%0d gv=%b dout=%h, want gnt=%b sel=%0d gv=%b dout=%h",
                           e.tag, $time, gnt, sel, gnt_valid, dout, e.gnt, e.sel, e.gv, e.dout);
               end else begin
                  passed++;
               end
            end
         end
      end
   end

   initial begin
      checks    = 0;
      passed    = 0;
      stim_done = 1'b0;
      rst_n     = 1'b0;
      mode      = 1'b0;
      req       = 4'b0000;
      din       = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

      // reset state, then idle
      cyc(1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 8'h00, 0);
      cyc(1'b0, 1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 8'h00, 0);
      gap(1'b0, 4'b0000, 0, 0);

      // test 1: fixed priority picks lowest set index
      own(1'b0, 4'b1010, 1, 1);
      gap(1'b0, 4'b0000, 1, 1);
      gap(1'b0, 4'b0000, 1, 1);
      own(1'b0, 4'b1100, 2, 1);
      gap(1'b0, 4'b0000, 2, 1);
      gap(1'b0, 4'b0000, 2, 1);

      // test 3: sole requester keeps the grant past MAX_HOLD
      for (int i = 0; i < 20; i++) own(1'b0, 4'b0001, 0, 3);
      gap(1'b0, 4'b0000, 0, 3);
      gap(1'b0, 4'b0000, 0, 3);

      // test 4: voluntary release, one-cycle handoff
      for (int i = 0; i < 3; i++) own(1'b0, 4'b0011, 0, 4);
      gap(1'b0, 4'b0010, 0, 4);
      own(1'b0, 4'b0010, 1, 4);
      own(1'b0, 4'b0010, 1, 4);
      gap(1'b0, 4'b0000, 1, 4);
      gap(1'b0, 4'b0000, 1, 4);

      // test 5: preemption alternates owners even in fixed-priority mode
      for (int i = 0; i < 8; i++) own(1'b0, 4'b0011, 0, 5);
      gap(1'b0, 4'b0011, 0, 5);
      for (int i = 0; i < 8; i++) own(1'b0, 4'b0011, 1, 5);
      gap(1'b0, 4'b0011, 1, 5);
      for (int i = 0; i < 8; i++) own(1'b0, 4'b0011, 0, 5);
      gap(1'b0, 4'b0000, 0, 5);
      gap(1'b0, 4'b0000, 0, 5);

      // test 2: round-robin rotation 0,1,2,3,0
      for (int n = 0; n < 5; n++) begin
         for (int i = 0; i < 8; i++) own(1'b1, 4'b1111, n % 4, 2);
         if (n < 4) gap(1'b1, 4'b1111, n % 4, 2);
      end
      gap(1'b0, 4'b0000, 0, 2);
      gap(1'b0, 4'b0000, 0, 2);

      // test 6: reset mid-grant clears outputs and the round-robin pointer
      for (int i = 0; i < 3; i++) own(1'b0, 4'b0100, 2, 6);
      cyc(1'b0, 1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 8'h00, 6);
      own(1'b1, 4'b1111, 0, 6);
      own(1'b1, 4'b1111, 0, 6);
      gap(1'b1, 4'b0000, 0, 6);
      gap(1'b1, 4'b0000, 0, 6);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      if (q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      stim_done = 1'b1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
